// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: RISC-V load/store funct3
// values and the owner tag of a pending read response.
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, debug and memory-side signals around dmem_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface dmem_arbiter_if #(parameter int ADDR_WIDTH = 14);
  logic                  cpu_req, cpu_we, cpu_stall, cpu_rvalid;
  logic [31:0]           cpu_addr, cpu_wdata, cpu_rdata;
  logic [2:0]            cpu_funct3;
  logic                  dbg_req, dbg_ready, dbg_we, dbg_rvalid;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic [31:0]           dbg_wdata, dbg_rdata;
  logic                  mem_en;
  logic [3:0]            mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata, mem_rdata;
  logic                  misaligned;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_funct3, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ready, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output misaligned
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_funct3, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ready, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  misaligned
  );
endinterface

// File: rtl/dmem_lane_fmt.sv
// Combinational byte-lane logic: store enables/data placement, misaligned
// detect for the request, and sign/zero extension of the returned word.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic        req_we_i,
  input  logic [2:0]  req_f3_i,
  input  logic [1:0]  req_off_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  rsp_f3_i,
  input  logic [1:0]  rsp_off_i,
  input  logic        rsp_mis_i,
  input  logic [31:0] rsp_rdata_i,
  output logic        mis_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);
  logic [15:0] sh;

  always_comb begin
    mis_o   = 1'b0;
    be_o    = 4'b0000;
    wdata_o = req_wdata_i;
    case (req_f3_i)
      F3_B: begin
        be_o    = 4'b0001 << req_off_i;
        wdata_o = {4{req_wdata_i[7:0]}};
      end
      F3_H: begin
        mis_o   = (req_off_i == 2'd3);
        be_o    = 4'b0011 << req_off_i;
        // offset 1 straddles the middle lanes; 0 and 2 use plain replication
        wdata_o = (req_off_i == 2'd1) ? {req_wdata_i[7:0], req_wdata_i[15:0], req_wdata_i[15:8]}
                                      : {2{req_wdata_i[15:0]}};
      end
      F3_W: begin
        mis_o = (req_off_i != 2'd0);
        be_o  = 4'b1111;
      end
      F3_BU:   mis_o = req_we_i;
      F3_HU:   mis_o = req_we_i | (req_off_i == 2'd3);
      default: mis_o = 1'b1;
    endcase
    if (mis_o || !req_we_i) be_o = 4'b0000;
  end

  always_comb begin
    sh      = 16'(rsp_rdata_i >> {rsp_off_i, 3'b000});
    rdata_o = 32'h0;
    case (rsp_f3_i)
      F3_B:    rdata_o = {{24{sh[7]}}, sh[7:0]};
      F3_H:    rdata_o = {{16{sh[15]}}, sh};
      F3_W:    rdata_o = rsp_rdata_i;
      F3_BU:   rdata_o = {24'h0, sh[7:0]};
      F3_HU:   rdata_o = {16'h0, sh};
      default: rdata_o = 32'h0;
    endcase
    if (rsp_mis_i) rdata_o = 32'h0;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU has priority, a starvation counter
// lets the debug port through once after STARVE_LIMIT consecutive losses.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 14,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q, starve_d;
  owner_e        own_q, own_d;
  logic [1:0]    off_q;
  logic [2:0]    f3_q;
  logic          mis_q;
  logic          gnt_cpu, gnt_dbg, cpu_mis;
  logic [3:0]    cpu_be;
  logic [31:0]   cpu_wd, cpu_ld;
  logic          unused_addr;

  assign unused_addr = ^bus.cpu_addr[31:ADDR_WIDTH+2];

  dmem_lane_fmt u_fmt (
    .req_we_i   (bus.cpu_we),
    .req_f3_i   (bus.cpu_funct3),
    .req_off_i  (bus.cpu_addr[1:0]),
    .req_wdata_i(bus.cpu_wdata),
    .rsp_f3_i   (f3_q),
    .rsp_off_i  (off_q),
    .rsp_mis_i  (mis_q),
    .rsp_rdata_i(bus.mem_rdata),
    .mis_o      (cpu_mis),
    .be_o       (cpu_be),
    .wdata_o    (cpu_wd),
    .rdata_o    (cpu_ld)
  );

  always_comb begin
    gnt_cpu = !rst && bus.cpu_req && !(bus.dbg_req && starve_q == LIMIT);
    gnt_dbg = !rst && bus.dbg_req && !gnt_cpu;
    if (!bus.dbg_req || gnt_dbg) starve_d = '0;
    else if (starve_q != LIMIT)  starve_d = starve_q + 1'b1;
    else                         starve_d = starve_q;
    // only reads produce a response next cycle
    if (gnt_cpu && !bus.cpu_we)      own_d = OWN_CPU;
    else if (gnt_dbg && !bus.dbg_we) own_d = OWN_DBG;
    else                             own_d = OWN_NONE;
  end

  assign bus.cpu_stall  = bus.cpu_req && !gnt_cpu;
  assign bus.dbg_ready  = gnt_dbg;
  assign bus.mem_en     = gnt_cpu || gnt_dbg;
  assign bus.mem_we     = gnt_cpu ? cpu_be : ((gnt_dbg && bus.dbg_we) ? 4'hF : 4'h0);
  assign bus.mem_addr   = gnt_cpu ? bus.cpu_addr[ADDR_WIDTH+1:2] : bus.dbg_addr;
  assign bus.mem_wdata  = gnt_cpu ? cpu_wd : bus.dbg_wdata;
  assign bus.cpu_rvalid = (own_q == OWN_CPU);
  assign bus.cpu_rdata  = bus.cpu_rvalid ? cpu_ld : 32'h0;
  assign bus.dbg_rvalid = (own_q == OWN_DBG);
  assign bus.dbg_rdata  = bus.dbg_rvalid ? bus.mem_rdata : 32'h0;
  assign bus.misaligned = mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      own_q    <= OWN_NONE;
      off_q    <= 2'd0;
      f3_q     <= 3'd0;
      mis_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      own_q    <= own_d;
      mis_q    <= gnt_cpu && cpu_mis;
      if (gnt_cpu) begin
        off_q <= bus.cpu_addr[1:0];
        f3_q  <= bus.cpu_funct3;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed test-plan cases then randomized traffic,
// all checked against a byte-level model of memory and arbitration.
module tb_dmem_arbiter;
  import dmem_pkg::*;
  localparam int AW = 14, LIM = 4;

  logic clk = 1'b0, rst = 1'b1;
  int   nassert = 0, nfail = 0;

  dmem_arbiter_if #(.ADDR_WIDTH(AW)) bus();
  dmem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // synchronous single-port memory behind the arbiter
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk)
    if (bus.mem_en) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      for (int i = 0; i < 4; i++)
        if (bus.mem_we[i]) mem[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    end

  logic [31:0] refm [0:7];
  int          lose;
  bit          e_cv, e_dv, e_mis, last_gc, last_gd;
  logic [31:0] e_cd, e_dd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nassert++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int acc_size(input logic we, input logic [2:0] f3);
    case (f3)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      3'd4: return we ? 0 : 1;
      3'd5: return we ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  task automatic cpu(input bit req, input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_funct3 = f3; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic dbg(input bit req, input bit we, input int a, input logic [31:0] d);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = AW'(a); bus.dbg_wdata = d;
  endtask

  // Called at posedge+1 with inputs driven; checks, updates model, advances one clock.
  task automatic cycle();
    int sz, off, w; bit legal, gc, gd; logic [31:0] bm, v; logic [2:0] f3;
    #1;
    chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(e_cv));
    chk("cpu_rdata", bus.cpu_rdata, e_cd);
    chk("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(e_dv));
    chk("dbg_rdata", bus.dbg_rdata, e_dd);
    chk("misaligned", 32'(bus.misaligned), 32'(e_mis));
    gc = bus.cpu_req && !(bus.dbg_req && lose >= LIM);
    gd = bus.dbg_req && !gc;
    chk("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req && !gc));
    chk("dbg_ready", 32'(bus.dbg_ready), 32'(gd));
    chk("mem_en", 32'(bus.mem_en), 32'(gc || gd));
    e_cv = 0; e_dv = 0; e_mis = 0; e_cd = 0; e_dd = 0;
    if (gc) begin
      off = int'(bus.cpu_addr[1:0]); w = int'(bus.cpu_addr[AW+1:2]); f3 = bus.cpu_funct3;
      sz = acc_size(bus.cpu_we, f3);
      legal = (sz != 0) && (off + sz <= 4);
      bm = 32'h0;
      if (legal && bus.cpu_we) for (int i = off; i < off + sz; i++) bm[8*i +: 8] = 8'hFF;
      chk("cpu mem_addr", 32'(bus.mem_addr), 32'(w));
      chk("cpu mem_we", 32'(bus.mem_we), 32'({bm[24], bm[16], bm[8], bm[0]}));
      v = bus.cpu_wdata << (8*off);
      if (bm != 0) chk("cpu mem_wdata", bus.mem_wdata & bm, v & bm);
      refm[w[2:0]] = (refm[w[2:0]] & ~bm) | (v & bm);
      e_mis = !legal;
      if (!bus.cpu_we) begin
        e_cv = 1;
        if (legal) begin
          v = refm[w[2:0]] >> (8*off);
          if (sz == 1)      v = f3[2] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
          else if (sz == 2) v = f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
          e_cd = v;
        end
      end
    end else if (gd) begin
      chk("dbg mem_addr", 32'(bus.mem_addr), 32'(bus.dbg_addr));
      if (bus.dbg_we) begin
        chk("dbg mem_we", 32'(bus.mem_we), 32'hF);
        chk("dbg mem_wdata", bus.mem_wdata, bus.dbg_wdata);
        refm[bus.dbg_addr[2:0]] = bus.dbg_wdata;
      end else begin
        chk("dbg read mem_we", 32'(bus.mem_we), 32'h0);
        e_dv = 1; e_dd = refm[bus.dbg_addr[2:0]];
      end
    end else chk("idle mem_we", 32'(bus.mem_we), 32'h0);
    lose = (bus.dbg_req && !gd) ? ((lose < LIM) ? lose + 1 : LIM) : 0;
    last_gc = gc; last_gd = gd;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input bit creq);
    chk("rst mem_en", 32'(bus.mem_en), 32'h0);
    chk("rst mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst cpu_stall", 32'(bus.cpu_stall), 32'(creq));
    chk("rst dbg_ready", 32'(bus.dbg_ready), 32'h0);
    chk("rst cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
    chk("rst cpu_rdata", bus.cpu_rdata, 32'h0);
    chk("rst dbg_rvalid", 32'(bus.dbg_rvalid), 32'h0);
    chk("rst dbg_rdata", bus.dbg_rdata, 32'h0);
    chk("rst misaligned", 32'(bus.misaligned), 32'h0);
  endtask

  initial begin
    cpu(1, 0, F3_W, 0, 0); dbg(1, 0, 0, 0);
    lose = 0; e_cv = 0; e_dv = 0; e_mis = 0; e_cd = 0; e_dd = 0;
    repeat (2) @(posedge clk);
    #1; chk_reset_outputs(1'b1);
    cpu(0, 0, F3_W, 0, 0); dbg(0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // load words 0..7 through the debug port
    for (int w = 0; w < 8; w++) begin
      dbg(1, 1, w, (w == 0) ? 32'h8899AABB : $urandom);
      cycle();
    end
    dbg(0, 0, 0, 0);

    cpu(1, 0, F3_B, 32'h1, 0);  cycle(); chk("LB byte1", bus.cpu_rdata, 32'hFFFFFFAA);
    cpu(1, 0, F3_BU, 32'h1, 0); cycle(); chk("LBU byte1", bus.cpu_rdata, 32'h000000AA);
    cpu(1, 0, F3_H, 32'h3, 0);  #1; chk("LH mis stall", 32'(bus.cpu_stall), 32'h0);
    cycle();
    chk("LH mis rdata", bus.cpu_rdata, 32'h0);
    chk("LH mis pulse", 32'(bus.misaligned), 32'h1);
    cpu(1, 1, F3_H, 32'h3, 32'h11223344); #1; chk("SH mis mem_we", 32'(bus.mem_we), 32'h0);
    cycle();
    cpu(1, 0, F3_W, 32'h0, 0); cycle(); chk("SH mis word", bus.cpu_rdata, 32'h8899AABB);
    cpu(1, 1, F3_B, 32'h2, 32'hAABBCCDD); #1;
    chk("SB mem_we", 32'(bus.mem_we), 32'h4);
    chk("SB mem_wdata", bus.mem_wdata, 32'hDDDDDDDD);
    cycle();
    cpu(1, 0, F3_W, 32'h0, 0); cycle(); chk("SB word", bus.cpu_rdata, 32'h88DDAABB);
    cpu(0, 0, F3_W, 0, 0); dbg(1, 1, 7, 32'h12345678); cycle();
    dbg(0, 0, 0, 0); cpu(1, 0, F3_W, 32'h1C, 0); cycle();
    chk("dbg wr then LW", bus.cpu_rdata, 32'h12345678);

    // both held: debug wins every fifth cycle
    cpu(1, 0, F3_W, 32'h4, 0); dbg(1, 0, 3, 0);
    for (int k = 0; k < 15; k++) begin
      #1; chk("starve stall", 32'(bus.cpu_stall), 32'((k % 5) == 4));
      cycle();
    end
    cpu(0, 0, F3_W, 0, 0); dbg(0, 0, 0, 0); cycle();

    // reset between grant and response discards the load
    cpu(1, 0, F3_W, 32'h8, 0); #1;
    chk("pre-rst grant", 32'(bus.mem_en), 32'h1);
    #3 rst = 1'b1;
    @(posedge clk); #1; chk_reset_outputs(1'b1);
    cpu(0, 0, F3_W, 0, 0); rst = 1'b0;
    lose = 0; e_cv = 0; e_dv = 0; e_mis = 0; e_cd = 0; e_dd = 0;
    @(posedge clk); #1;
    chk("post-rst cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
    last_gc = 1; last_gd = 1;

    for (int c = 0; c < 400; c++) begin
      if (!(bus.cpu_req && !last_gc))
        cpu($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
            32'($urandom_range(0, 31)), $urandom);
      if (!(bus.dbg_req && !last_gd))
        dbg($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom);
      cycle();
    end
    cpu(0, 0, F3_W, 0, 0); dbg(0, 0, 0, 0); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
